// File: rtl/slow_clock_pkg.sv
// Shared constants for the 4 Hz slow-clock divider and its receiver, so both ends
// agree on the nominal period, plus the receiver's lock-qualification states.
package slow_clock_pkg;

  localparam int unsigned DEF_HALF_CYCLES   = 12_500_001;
  localparam int unsigned DEF_TOL           = 1024;
  localparam int unsigned DEF_TICKS_PER_SEC = 4;
  localparam int unsigned DEF_CNT_W         = 26;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus one history flop and
// registered single-cycle rise/fall pulses.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/slow_clock_tick_rx.sv
// Receive end of the slow-clock divider: edge ticks, rise-to-rise period measurement,
// lock/loss qualification and a once-per-second pulse for the time-keeping logic.
module slow_clock_tick_rx
  import slow_clock_pkg::*;
#(
  parameter int unsigned HALF_CYCLES   = DEF_HALF_CYCLES,
  parameter int unsigned TOL           = DEF_TOL,
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             sec_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned WIN_LO = 2 * HALF_CYCLES - TOL;
  localparam int unsigned WIN_HI = 2 * HALF_CYCLES + TOL;
  localparam int unsigned MEAS_W = CNT_W + 1;
  localparam int unsigned SCNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                sec_q, sec_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;
  logic [MEAS_W-1:0]   measured;
  logic                in_window;
  logic                timeout;

  sync_edge_detect u_sync (
    .clk  (clk_in),
    .rst  (reset),
    .din  (slow_clk_in),
    .rise (tick_rise),
    .fall (tick_fall)
  );

  // Period counter restarts on every rise and parks at all-ones when the input dies.
  always_comb begin
    measured  = MEAS_W'(pcnt_q) + MEAS_W'(1);
    in_window = (measured >= MEAS_W'(WIN_LO)) && (measured <= MEAS_W'(WIN_HI));
    timeout   = !tick_rise && (pcnt_q == CNT_W'(WIN_HI));
    if (tick_rise)    pcnt_d = '0;
    else if (&pcnt_q) pcnt_d = pcnt_q;
    else              pcnt_d = pcnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    scnt_d   = scnt_q;
    sec_d    = 1'b0;

    if (tick_rise && (state_q != SEARCH)) begin
      period_d = (&pcnt_q) ? pcnt_q : measured[CNT_W-1:0];
    end

    case (state_q)
      SEARCH: begin
        if (tick_rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (tick_rise) begin
          if (in_window) begin
            state_d = LOCKED;
            scnt_d  = SCNT_W'(1);
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (tick_rise) begin
          if (!in_window) begin
            state_d = MEASURE;
          end else if (scnt_q == SCNT_W'(TICKS_PER_SEC - 1)) begin
            scnt_d = '0;
            sec_d  = 1'b1;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOST: begin
        if (tick_rise) state_d = MEASURE;
      end
      default: state_d = SEARCH;
    endcase

    // Second count is only meaningful while locked.
    if (state_d != LOCKED) scnt_d = '0;
    locked_d = (state_d == LOCKED);
    lost_d   = (state_d == LOST);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      pcnt_q   <= '0;
      period_q <= '0;
      scnt_q   <= '0;
      sec_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      scnt_q   <= scnt_d;
      sec_q    <= sec_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign sec_pulse  = sec_q;
  assign period_cnt = period_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_slow_clock_tick_rx.sv
// Bench for slow_clock_tick_rx: scenario tasks driving the slow clock, checked every
// cycle against a timestamp-based model of ticks, period, lock, loss and seconds.
module tb_slow_clock_tick_rx;

  localparam int unsigned HALF = 10;
  localparam int unsigned TOL  = 2;
  localparam int unsigned TPS  = 4;
  localparam int unsigned CW   = 8;
  localparam int WLO     = 2 * HALF - TOL;
  localparam int WHI     = 2 * HALF + TOL;
  localparam int TO_DIST = WHI + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow = 1'b0;
  logic          tick_rise, tick_fall, sec_pulse, locked, lost;
  logic [CW-1:0] period_cnt;
  logic [CW+4:0] obs;
  logic [CW+4:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: input history (bit k = input k cycles ago) and timestamped lock status
  logic [4:0] hist = '0;
  bit m_started, m_locked, m_lost, m_pulse;
  int m_last, m_sec, m_period;

  slow_clock_tick_rx #(
    .HALF_CYCLES   (HALF),
    .TOL           (TOL),
    .TICKS_PER_SEC (TPS),
    .CNT_W         (CW)
  ) dut (
    .clk_in      (clk),
    .reset       (rst),
    .slow_clk_in (slow),
    .tick_rise   (tick_rise),
    .tick_fall   (tick_fall),
    .sec_pulse   (sec_pulse),
    .period_cnt  (period_cnt),
    .locked      (locked),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  assign obs = {tick_rise, tick_fall, sec_pulse, locked, lost, period_cnt};

  // One clock cycle: drive input/reset just after the edge, predict this cycle's
  // outputs, advance the model, then wait for the sampling (falling) edge.
  task automatic step(input logic v, input logic r);
    logic tr, tf;
    int meas;
    @(posedge clk);
    #1;
    rst  = r;
    slow = v;
    cyc++;
    if (r) begin
      hist = '0; m_started = 0; m_locked = 0; m_lost = 0; m_pulse = 0;
      m_sec = 0; m_period = 0; m_last = 0;
    end else begin
      hist = {hist[3:0], v};
    end
    tr = hist[3] & ~hist[4];
    tf = ~hist[3] & hist[4];
    exp_v = {tr, tf, m_pulse, m_locked, m_lost, CW'(m_period)};
    m_pulse = 0;
    if (!r) begin
      if (tr) begin
        if (!m_started) begin
          m_started = 1;
        end else begin
          meas = cyc - m_last;
          if (meas > 255) meas = 255;
          m_period = meas;
          if (meas >= WLO && meas <= WHI && !m_lost) begin
            if (m_locked) begin
              m_sec   = (m_sec + 1) % TPS;
              m_pulse = (m_sec == 0);
            end else begin
              m_locked = 1;
              m_sec    = 1;
            end
          end else begin
            m_locked = 0;
            m_sec    = 0;
          end
          m_lost = 0;
        end
        m_last = cyc;
      end else if (m_started && !m_lost && (cyc - m_last == TO_DIST)) begin
        m_lost = 1; m_locked = 0; m_sec = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic wave(input int i, input int hi, input int lo, input bit low_first);
    int ph;
    ph = i % (hi + lo);
    return low_first ? logic'(ph >= lo) : logic'(ph < hi);
  endfunction

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      step(logic'((i / 3) % 2), 1'b1);
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc, obs);
      end
    end
  endtask

  task automatic test_nominal();
    int first_lock, p1, p2, n_pulse, n_rise;
    first_lock = -1; p1 = -1; p2 = -1; n_pulse = 0; n_rise = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(wave(i, 10, 10, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (locked === 1'b1 && first_lock < 0) first_lock = i;
      if (tick_rise === 1'b1) n_rise++;
      if (sec_pulse === 1'b1) begin
        if (n_pulse == 0) p1 = i; else if (n_pulse == 1) p2 = i;
        n_pulse++;
      end
    end
    n_checks++;
    if (first_lock != 34) begin n_fail++; $display("FAIL lock_latency got=%0d exp=34", first_lock); end
    n_checks++;
    if (n_rise != 10) begin n_fail++; $display("FAIL tick_rise_count got=%0d exp=10", n_rise); end
    n_checks++;
    if (p1 != 94 || p2 != 174 || n_pulse != 2) begin
      n_fail++;
      $display("FAIL sec_pulse_pos got=%0d,%0d n=%0d exp=94,174 n=2", p1, p2, n_pulse);
    end
    n_checks++;
    if (period_cnt !== CW'(20) || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_final got period=%0d locked=%b exp period=20 locked=1", period_cnt, locked);
    end
  endtask

  task automatic test_off_freq();
    int n_lock;
    n_lock = 0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      step(wave(i, 12, 12, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL off_freq cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (locked !== 1'b0) n_lock++;
    end
    n_checks++;
    if (n_lock != 0 || period_cnt !== CW'(24)) begin
      n_fail++;
      $display("FAIL off_freq_final got locked_cycles=%0d period=%0d exp 0 and 24", n_lock, period_cnt);
    end
  endtask

  task automatic test_loss();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(wave(i, 10, 10, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_lock cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_hold cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (j == 16 || j == 17) begin
        n_checks++;
        if (lost !== logic'(j == 17) || locked !== logic'(j == 16)) begin
          n_fail++;
          $display("FAIL loss_timing j=%0d got lost=%b locked=%b", j, lost, locked);
        end
      end
    end
    for (int k = 0; k < 60; k++) begin
      step(wave(k, 10, 10, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL loss_resume cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (k == 13 || k == 14 || k == 34) begin
        n_checks++;
        if (lost !== logic'(k == 13) || locked !== logic'(k == 34)) begin
          n_fail++;
          $display("FAIL relock_timing k=%0d got lost=%b locked=%b", k, lost, locked);
        end
      end
    end
  endtask

  task automatic test_short_period();
    do_reset();
    for (int i = 0; i < 65; i++) begin
      step((i < 60) ? wave(i, 10, 10, 1'b1) : 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL short_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
    for (int k = 0; k < 100; k++) begin
      step(wave(k, 10, 10, 1'b0), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL short_post cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (k == 4) begin
        n_checks++;
        if (period_cnt !== CW'(15) || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL short_unlock got period=%0d locked=%b exp 15 and 0", period_cnt, locked);
        end
      end
      if (k == 24) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL short_relock got locked=%b exp 1", locked); end
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(wave(i, 10, 10, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL mid_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_locked_before got=%b exp=1", locked); end
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (obs !== '0) begin n_fail++; $display("FAIL mid_reset cyc=%0d got=%b exp=0", cyc, obs); end
    end
    for (int k = 0; k < 60; k++) begin
      step(wave(k, 10, 10, 1'b1), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL mid_post cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      if (k == 33 || k == 34) begin
        n_checks++;
        if (locked !== logic'(k == 34)) begin
          n_fail++;
          $display("FAIL mid_relock k=%0d got locked=%b", k, locked);
        end
      end
    end
  endtask

  task automatic test_random();
    int total;
    total = 0;
    while (total < 900) begin
      logic [1:0] seq[$];
      int hi, lo, roll;
      hi   = $urandom_range(13, 7);
      lo   = $urandom_range(13, 7);
      roll = $urandom_range(24, 0);
      seq  = {};
      if (roll == 0) repeat (2) seq.push_back(2'b10);
      if (roll == 1) repeat (30) seq.push_back(2'b00);
      repeat (lo) seq.push_back(2'b00);
      repeat (hi) seq.push_back(2'b01);
      foreach (seq[k]) begin
        step(seq[k][0], seq[k][1]);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v); end
      end
      total += seq.size();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    test_reset();
    test_nominal();
    test_off_freq();
    test_loss();
    test_short_period();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
